multiport_regfile: RTL and testbench

//  Parametrised general-purpose register file for the next-generation (dual-issue) CPU datapath.
//  - Two asynchronous read ports and two posedge write ports, with per-byte write enables.
//  - Optional hard-wired zero register.
//  - After reset, a sweep FSM clears every entry, one per cycle, and then raises `ready`.
//  - Sits between decode (read addresses) and writeback (write ports).

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_clear_fsm.sv | 51 +++++
 rtl/multiport_regfile.sv | 106 ++++++++++
 tb/tb_multiport_regfile.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_pkg : shared types, default widths and byte-merge helper
// Rev 1.0
// ---------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_clear_fsm : post-reset clear sweep counter and CLEAR/RUN state
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output rf_state_t         state,
  output logic [ADDR_W-1:0] clr_cnt,
  output logic              clr_we,
  output logic              ready
);

  rf_state_t         state_nxt;
  logic [ADDR_W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = clr_cnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = clr_cnt + ADDR_W'(1);
        // Last entry cleared this cycle; the array is fully zeroed at the edge.
        if (&clr_cnt) state_nxt = RUN;
      end
      RUN: ;
      default: state_nxt = CLEAR;
    endcase
  end

  assign ready = (state == RUN);

endmodule
`default_nettype wire

// File: rtl/multiport_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multiport_regfile : 2R/2W byte-enabled register file with clear sweep
// Optional feature: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding)
// Rev 1.0
// ---------------------------------------------------------------------------
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ra,
  input  logic [ADDR_W-1:0]   rb,
  output logic [DATA_W-1:0]   bus_a,
  output logic [DATA_W-1:0]   bus_b,
  input  logic                we0,
  input  logic [ADDR_W-1:0]   rw0,
  input  logic [DATA_W/8-1:0] wbe0,
  input  logic [DATA_W-1:0]   wd0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   rw1,
  input  logic [DATA_W/8-1:0] wbe1,
  input  logic [DATA_W-1:0]   wd1,
  output logic                ready
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  rf_state_t         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_we;

  regfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk     (clk),
    .rst     (rst),
    .state   (state),
    .clr_cnt (clr_cnt),
    .clr_we  (clr_we),
    .ready   (ready)
  );

  function automatic logic [DATA_W-1:0] word_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      res[8*k +: 8] = byte_merge(old_w[8*k +: 8], new_w[8*k +: 8], be[k]);
    end
    return res;
  endfunction

  logic              run;
  logic              wr0_ok, wr1_ok;
  logic [DATA_W-1:0] merged0, merged1, base1;

  assign run    = (state == RUN);
  assign wr0_ok = run && we0 && !((ZERO_REG != 0) && (rw0 == '0));
  assign wr1_ok = run && we1 && !((ZERO_REG != 0) && (rw1 == '0));

  // Port 1 builds on port 0's result for a shared address, so per-byte
  // merging falls out naturally and port 1 wins overlapping bytes.
  assign merged0 = word_merge(mem[rw0], wd0, wbe0);
  assign base1   = (wr0_ok && (rw0 == rw1)) ? merged0 : mem[rw1];
  assign merged1 = word_merge(base1, wd1, wbe1);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
    end else if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wr0_ok) mem[rw0] <= merged0;
      if (wr1_ok) mem[rw1] <= merged1;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  assign rd_addr[0] = ra;
  assign rd_addr[1] = rb;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr0_ok && (rw0 == rd_addr[p])) rd_data[p] = word_merge(rd_data[p], wd0, wbe0);
      if (wr1_ok && (rw1 == rd_addr[p])) rd_data[p] = word_merge(rd_data[p], wd1, wbe1);
`endif
      if (!run || ((ZERO_REG != 0) && (rd_addr[p] == '0))) rd_data[p] = '0;
    end
  end

  assign bus_a = rd_data[0];
  assign bus_b = rd_data[1];

endmodule
`default_nettype wire

// File: tb/tb_multiport_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multiport_regfile : self-checking bench, ZERO_REG=1 and ZERO_REG=0 copies
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_multiport_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ra = '0, rb = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  rw0 = '0, rw1 = '0;
  logic [3:0]  wbe0 = '0, wbe1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [31:0] bus_a, bus_b, bus_a_nz, bus_b_nz;
  logic        ready, ready_nz;

  always #5 clk = ~clk;

  multiport_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .bus_a(bus_a), .bus_b(bus_b),
    .we0(we0), .rw0(rw0), .wbe0(wbe0), .wd0(wd0),
    .we1(we1), .rw1(rw1), .wbe1(wbe1), .wd1(wd1), .ready(ready)
  );

  multiport_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb), .bus_a(bus_a_nz), .bus_b(bus_b_nz),
    .we0(we0), .rw0(rw0), .wbe0(wbe0), .wd0(wd0),
    .we1(we1), .rw1(rw1), .wbe1(wbe1), .wd1(wd1), .ready(ready_nz)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: contents for each build, plus edges counted since reset release.
  logic [31:0] m1 [32];
  logic [31:0] m0 [32];
  int          since  = 0;
  bit          mready = 1'b0;
  bit          mvalid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      since  = 0;
      mready = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      if (!mready) begin
        since++;
        if (since == 32) begin
          mready = 1'b1;
          for (int i = 0; i < 32; i++) begin
            m0[i] = '0;
            m1[i] = '0;
          end
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (we0 && wbe0[k]) begin
            m0[rw0][8*k +: 8] = wd0[8*k +: 8];
            if (rw0 != 0) m1[rw0][8*k +: 8] = wd0[8*k +: 8];
          end
        end
        for (int k = 0; k < 4; k++) begin
          if (we1 && wbe1[k]) begin
            m0[rw1][8*k +: 8] = wd1[8*k +: 8];
            if (rw1 != 0) m1[rw1][8*k +: 8] = wd1[8*k +: 8];
          end
        end
      end
    end
  end

  function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] a);
    logic [31:0] v;
    if (!mready) return 32'h0;
    if (zr && a == 0) return 32'h0;
    v = zr ? m1[a] : m0[a];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < 4; k++) begin
      if (we0 && rw0 == a && wbe0[k]) v[8*k +: 8] = wd0[8*k +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      if (we1 && rw1 == a && wbe1[k]) v[8*k +: 8] = wd1[8*k +: 8];
    end
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (mvalid) begin
      check("cyc_ready",    {31'b0, ready},    {31'b0, mready});
      check("cyc_ready_nz", {31'b0, ready_nz}, {31'b0, mready});
      check("cyc_bus_a",    bus_a,    exp_rd(1'b1, ra));
      check("cyc_bus_b",    bus_b,    exp_rd(1'b1, rb));
      check("cyc_bus_a_nz", bus_a_nz, exp_rd(1'b0, ra));
      check("cyc_bus_b_nz", bus_b_nz, exp_rd(1'b0, rb));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sweep_and_check(input string name);
    for (int k = 1; k <= 32; k++) begin
      tick();
      check(name, {31'b0, ready}, {31'b0, (k == 32)});
    end
  endtask

  task automatic all_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i);
      rb = 5'(31 - i);
      #1;
      check(name, bus_a, 32'h0);
      check(name, bus_a_nz, 32'h0);
      check(name, bus_b, 32'h0);
    end
  endtask

  initial begin
    // Reset for one edge, then the clear sweep with a write attempt mid-sweep.
    tick();
    rst = 1'b0;
    #1;
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_bus_a", bus_a, 32'h0);
    for (int k = 1; k <= 32; k++) begin
      if (k == 10) begin
        we0 = 1'b1; rw0 = 5'd3; wbe0 = 4'hF; wd0 = 32'hCAFEF00D;
      end else begin
        we0 = 1'b0;
      end
      tick();
      check("sweep_ready", {31'b0, ready}, {31'b0, (k == 32)});
    end
    we0 = 1'b0;
    all_zero("sweep_zero");
    ra = 5'd3;
    #1;
    check("clear_write_dropped", bus_a, 32'h0);

    // Byte enables.
    we0 = 1'b1; rw0 = 5'd5; wbe0 = 4'hF; wd0 = 32'h11223344;
    tick();
    wbe0 = 4'b0101; wd0 = 32'hAABBCCDD;
    tick();
    we0 = 1'b0; ra = 5'd5;
    #1;
    check("byte_enable", bus_a, 32'h11BB33DD);

    // Dual-write collision.
    we0 = 1'b1; rw0 = 5'd7; wbe0 = 4'hF;    wd0 = 32'hFFFF0000;
    we1 = 1'b1; rw1 = 5'd7; wbe1 = 4'b0011; wd1 = 32'h0000ABCD;
    tick();
    we0 = 1'b0; we1 = 1'b0; ra = 5'd7; rb = 5'd7;
    #1;
    check("collision_a", bus_a, 32'hFFFFABCD);
    check("collision_b", bus_b, 32'hFFFFABCD);

    // Zero register in both builds.
    we0 = 1'b1; rw0 = 5'd0; wbe0 = 4'hF; wd0 = 32'hDEADBEEF;
    tick();
    we0 = 1'b0; ra = 5'd0;
    #1;
    check("zero_reg",    bus_a,    32'h0);
    check("no_zero_reg", bus_a_nz, 32'hDEADBEEF);

    // Same-cycle write and read of r9.
    ra = 5'd9;
    we0 = 1'b1; rw0 = 5'd9; wbe0 = 4'hF; wd0 = 32'h12345678;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_pre", bus_a, 32'h12345678);
`else
    check("bypass_pre", bus_a, 32'h0);
`endif
    tick();
    we0 = 1'b0;
    #1;
    check("bypass_post", bus_a, 32'h12345678);

    // Mixed traffic on both ports, checked every cycle by the model.
    for (int i = 0; i < 12; i++) begin
      we0 = 1'b1; rw0 = 5'(i + 10); wbe0 = 4'(i + 1); wd0 = 32'h01010101 * (i + 1);
      we1 = (i % 3 == 0); rw1 = (i % 2 == 1) ? rw0 : 5'(i + 20);
      wbe1 = ~4'(i); wd1 = ~wd0;
      ra = rw0; rb = rw1;
      tick();
    end
    we0 = 1'b0; we1 = 1'b0;
    ra = 5'd0; rb = 5'd0;
    tick();

    // Reset from RUN, then reset again mid-sweep.
    rst = 1'b1;
    tick();
    #1;
    check("run_reset_ready", {31'b0, ready}, 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("mid_sweep_ready", {31'b0, ready}, 32'h0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_and_check("restart_ready");
    all_zero("restart_zero");

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
